// File: rtl/string_eval_pkg.sv
// rtl/string_eval_pkg.sv - shared string types, dispatcher states and round-robin select
package string_eval_pkg;

  localparam int STRING_CHARS      = 16;
  localparam int BITS_PER_CHAR     = 5;
  localparam int STRING_DATA_WIDTH = STRING_CHARS * BITS_PER_CHAR;
  localparam int RESULT_BITS       = 16;
  localparam int MAX_ENGINES       = 8;
  localparam int ENG_IDX_W         = 3;

  typedef logic [STRING_DATA_WIDTH-1:0] string_t;
  typedef logic [RESULT_BITS-1:0]       result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_DRAIN,
    ST_REPORT
  } disp_state_t;

  typedef struct packed {
    logic                 found;
    logic [ENG_IDX_W-1:0] idx;
  } rr_grant_t;

  // First ready engine at or above ptr, wrapping at n; lowest offset wins.
  function automatic rr_grant_t rr_select(input logic [MAX_ENGINES-1:0] ready,
                                          input logic [ENG_IDX_W-1:0]   ptr,
                                          input int                     n);
    rr_grant_t g;
    int        j;
    g = '0;
    for (int k = MAX_ENGINES - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (ready[j[ENG_IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = j[ENG_IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/candidate_queue.sv
// rtl/candidate_queue.sv - synchronous FIFO of candidate strings
module candidate_queue
  import string_eval_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  string_t i_push_data,
  input  logic    i_pop,
  output string_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  string_t     r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push is about to land in.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/pair_engine_dispatcher.sv
// rtl/pair_engine_dispatcher.sv - queues candidate strings, dispatches to pair engines, counts nice
module pair_engine_dispatcher #(
  parameter int NUM_ENGINES       = 2,
  parameter int QUEUE_DEPTH       = 4,
  parameter int STRING_DATA_WIDTH = 80,
  parameter int RESULT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         string_valid,
  input  logic [STRING_DATA_WIDTH-1:0] string_data,
  input  logic                         has_repeating_char,
  input  logic                         end_of_file,
  output logic [NUM_ENGINES-1:0]       eng_req_valid,
  input  logic [NUM_ENGINES-1:0]       eng_req_ready,
  output logic [STRING_DATA_WIDTH-1:0] eng_req_data,
  input  logic [NUM_ENGINES-1:0]       eng_done,
  input  logic [NUM_ENGINES-1:0]       eng_nice,
  output logic [RESULT_WIDTH-1:0]      nice_count,
  output logic                         result_valid,
  output logic                         overflow
);

  import string_eval_pkg::*;

  localparam int OUT_W = $clog2(NUM_ENGINES + 1);

  disp_state_t             r_state;
  logic [NUM_ENGINES-1:0]  r_req_valid;
  logic [ENG_IDX_W-1:0]    r_rr_ptr;
  logic [ENG_IDX_W-1:0]    r_grant_idx;
  logic [OUT_W-1:0]        r_outstanding;
  logic [RESULT_WIDTH-1:0] r_nice_count;
  logic                    r_eof_seen;
  logic                    r_result_valid;
  logic                    r_overflow;

  logic                    w_enq;
  logic                    w_full;
  logic                    w_empty;
  string_t                 w_head;
  logic                    w_handshake;
  logic [MAX_ENGINES-1:0]  w_ready_pad;
  rr_grant_t               w_grant;
  logic [NUM_ENGINES-1:0]  w_grant_onehot;
  logic [ENG_IDX_W-1:0]    w_next_ptr;
  logic [NUM_ENGINES-1:0]  w_done;
  logic [OUT_W-1:0]        w_done_cnt;
  logic [RESULT_WIDTH-1:0] w_nice_inc;

  assign w_enq       = string_valid && has_repeating_char;
  assign w_handshake = (r_state == ST_OFFER) && ((r_req_valid & eng_req_ready) != '0);

  candidate_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (w_enq),
    .i_push_data(string_data),
    .i_pop      (w_handshake),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_comb begin
    w_ready_pad = '0;
    w_ready_pad[NUM_ENGINES-1:0] = eng_req_ready;
    w_grant = rr_select(w_ready_pad, r_rr_ptr, NUM_ENGINES);
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      w_grant_onehot[i] = w_grant.found && (w_grant.idx == ENG_IDX_W'(i));
    end
  end

  assign w_next_ptr = (r_grant_idx == ENG_IDX_W'(NUM_ENGINES - 1)) ? '0 : r_grant_idx + ENG_IDX_W'(1);

  // Completions with nothing in flight are protocol errors and are dropped.
  assign w_done = (r_outstanding != '0) ? eng_done : '0;

  always_comb begin
    w_done_cnt = '0;
    w_nice_inc = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      w_done_cnt = w_done_cnt + OUT_W'(w_done[i]);
      w_nice_inc = w_nice_inc + RESULT_WIDTH'(w_done[i] & eng_nice[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_req_valid    <= '0;
      r_rr_ptr       <= '0;
      r_grant_idx    <= '0;
      r_outstanding  <= '0;
      r_nice_count   <= '0;
      r_eof_seen     <= 1'b0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_enq && w_full && !w_handshake) r_overflow <= 1'b1;
      if (end_of_file) r_eof_seen <= 1'b1;
      r_outstanding <= r_outstanding + OUT_W'(w_handshake) - w_done_cnt;
      r_nice_count  <= r_nice_count + w_nice_inc;

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            // Offer immediately when an engine is free so the dispatch rate is one per two cycles.
            r_state <= ST_OFFER;
            if (w_grant.found) begin
              r_req_valid <= w_grant_onehot;
              r_grant_idx <= w_grant.idx;
            end
          end else if (r_eof_seen) begin
            if (r_outstanding == '0) begin
              r_state        <= ST_REPORT;
              r_result_valid <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_OFFER: begin
          if (w_handshake) begin
            r_req_valid <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= ST_IDLE;
          end else if ((r_req_valid == '0) && w_grant.found) begin
            r_req_valid <= w_grant_onehot;
            r_grant_idx <= w_grant.idx;
          end
        end
        ST_DRAIN: begin
          if (!w_empty) begin
            r_state <= ST_IDLE;
          end else if (r_outstanding == '0) begin
            r_state        <= ST_REPORT;
            r_result_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          r_result_valid <= 1'b0;
          r_eof_seen     <= end_of_file;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign eng_req_valid = r_req_valid;
  assign eng_req_data  = w_head;
  assign nice_count    = r_nice_count;
  assign result_valid  = r_result_valid;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_pair_engine_dispatcher.sv
// tb/tb_pair_engine_dispatcher.sv - scoreboard bench for pair_engine_dispatcher
module tb_pair_engine_dispatcher;

  localparam int NE = 2;
  localparam int QD = 4;
  localparam int SW = 80;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          string_valid;
  logic [SW-1:0] string_data;
  logic          has_repeating_char;
  logic          end_of_file;
  logic [NE-1:0] eng_req_valid;
  logic [NE-1:0] eng_req_ready;
  logic [SW-1:0] eng_req_data;
  logic [NE-1:0] eng_done;
  logic [NE-1:0] eng_nice;
  logic [RW-1:0] nice_count;
  logic          result_valid;
  logic          overflow;

  pair_engine_dispatcher #(
    .NUM_ENGINES(NE), .QUEUE_DEPTH(QD), .STRING_DATA_WIDTH(SW), .RESULT_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .string_valid(string_valid), .string_data(string_data),
    .has_repeating_char(has_repeating_char), .end_of_file(end_of_file),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_req_data(eng_req_data),
    .eng_done(eng_done), .eng_nice(eng_nice), .nice_count(nice_count),
    .result_valid(result_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [SW-1:0] exp_data[$];
  int            exp_grant[$];
  int            exp_result[$];
  int            exp_total = 0;

  bit            eng_busy[NE];
  bit            eng_pending[NE];
  bit            eng_verdict[NE];
  int            eng_cnt[NE];
  int            eng_lat[NE];
  bit            hold[NE];
  logic [NE-1:0] force_mask = '0;
  bit            model_clear = 1'b1;

  int cyc = 0, hs_cnt = 0, res_cnt = 0, vld_cycles = 0;
  int last_done_cyc = 0, last_res_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine models plus output monitor, all evaluated on the falling edge.
  initial begin
    eng_req_ready = '0;
    eng_done      = '0;
    eng_nice      = '0;
    for (int i = 0; i < NE; i++) begin
      eng_busy[i] = 0; eng_pending[i] = 0; eng_verdict[i] = 0; eng_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (result_valid) begin
        res_cnt++;
        last_res_cyc = cyc;
        if (exp_result.size() == 0) check("result_expected", 0, 1);
        else check("nice_at_result", nice_count, exp_result.pop_front());
      end
      if (eng_req_valid != '0) vld_cycles++;
      eng_done = '0;
      eng_nice = '0;
      for (int i = 0; i < NE; i++) begin
        if (model_clear) begin
          eng_busy[i] = 0;
          eng_pending[i] = 0;
        end else if (eng_busy[i]) begin
          eng_cnt[i]--;
          if (force_mask[i] || eng_cnt[i] <= 0) begin
            eng_busy[i] = 0;
            eng_done[i] = 1'b1;
            eng_nice[i] = eng_verdict[i];
            last_done_cyc = cyc;
          end
        end else if (eng_pending[i]) begin
          eng_pending[i] = 0;
          eng_busy[i] = 1;
          eng_cnt[i] = eng_lat[i];
        end
        eng_req_ready[i] = !eng_busy[i] && !eng_pending[i] && !hold[i];
      end
      force_mask = '0;
      for (int i = 0; i < NE; i++) begin
        if (eng_req_valid[i] && eng_req_ready[i] && !reset) begin
          hs_cnt++;
          eng_pending[i] = 1;
          eng_verdict[i] = eng_req_data[0];
          check("req_onehot", $countones(eng_req_valid), 1);
          if (exp_data.size() == 0) check("data_expected", 0, 1);
          else check("req_data", eng_req_data, exp_data.pop_front());
          if (exp_grant.size() > 0) check("grant_idx", i, exp_grant.pop_front());
        end
      end
    end
  end

  function automatic logic [SW-1:0] mk(input bit v);
    logic [SW-1:0] d;
    d = SW'({$urandom(), $urandom(), $urandom()});
    d[0] = v;
    return d;
  endfunction

  task automatic send_str(input logic [SW-1:0] d, input bit rep, input bit eof, input bit accept);
    @(negedge clk);
    string_valid = 1'b1; string_data = d; has_repeating_char = rep; end_of_file = eof;
    if (rep && accept) begin
      exp_data.push_back(d);
      exp_total += int'(d[0]);
    end
    if (eof) exp_result.push_back(exp_total);
    @(negedge clk);
    string_valid = 1'b0; has_repeating_char = 1'b0; end_of_file = 1'b0;
  endtask

  task automatic send_eof();
    @(negedge clk);
    end_of_file = 1'b1;
    exp_result.push_back(exp_total);
    @(negedge clk);
    end_of_file = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, input string tag, output int lat);
    int start;
    start = res_cnt;
    lat = 0;
    while (res_cnt == start && lat < max_cyc) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, "_result_seen"}, res_cnt - start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear = 1'b1;
    exp_data.delete(); exp_grant.delete(); exp_result.delete();
    exp_total = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, h0, r0, v0;
    logic [RW-1:0] nb;
    bit t2_v[6] = '{1, 0, 1, 1, 0, 1};
    reset = 1'b1; string_valid = 0; string_data = '0; has_repeating_char = 0; end_of_file = 0;
    for (int i = 0; i < NE; i++) begin hold[i] = 0; eng_lat[i] = 3; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear = 1'b0;
    #1;
    check("rst_nice", nice_count, 0);
    check("rst_result", result_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_req_valid", eng_req_valid, 0);

    // single string, one usable engine, slow verdict
    hold[1] = 1; eng_lat[0] = 20;
    h0 = hs_cnt; r0 = res_cnt;
    exp_grant.push_back(0);
    send_str(mk(1), 1, 0, 1);
    repeat (30) @(negedge clk);
    send_eof();
    wait_result(10, "t1", lat);
    repeat (3) @(negedge clk);
    #1;
    check("t1_grants", hs_cnt - h0, 1);
    check("t1_pulses", res_cnt - r0, 1);
    check("t1_after_done", last_res_cyc > last_done_cyc, 1);
    hold[1] = 0;
    do_reset();

    // round-robin alternation
    eng_lat[0] = 1; eng_lat[1] = 1;
    h0 = hs_cnt;
    for (int k = 0; k < 6; k++) begin
      exp_grant.push_back(k % 2);
      send_str(mk(t2_v[k]), 1, 0, 1);
    end
    repeat (6) @(negedge clk);
    send_eof();
    wait_result(20, "t2", lat);
    check("t2_grants", hs_cnt - h0, 6);
    check("t2_nice", nice_count, 4);
    check("t2_grant_q", exp_grant.size(), 0);
    do_reset();

    // non-candidates are filtered
    v0 = vld_cycles;
    for (int k = 0; k < 3; k++) send_str(mk(1), 0, 0, 0);
    send_eof();
    wait_result(3, "t3", lat);
    check("t3_no_req", vld_cycles - v0, 0);
    check("t3_latency", lat <= 3, 1);
    check("t3_nice", nice_count, 0);
    do_reset();

    // queue overflow with engines held
    hold[0] = 1; hold[1] = 1; eng_lat[0] = 2; eng_lat[1] = 2;
    repeat (2) @(negedge clk);
    h0 = hs_cnt;
    send_str(mk(1), 1, 0, 1);
    send_str(mk(1), 1, 0, 1);
    send_str(mk(0), 1, 0, 1);
    send_str(mk(1), 1, 0, 1);
    #1;
    check("t4_ovf_before", overflow, 0);
    send_str(mk(1), 1, 0, 0);
    #1;
    check("t4_ovf", overflow, 1);
    hold[0] = 0; hold[1] = 0;
    repeat (20) @(negedge clk);
    #1;
    check("t4_ovf_sticky", overflow, 1);
    send_eof();
    wait_result(10, "t4", lat);
    check("t4_grants", hs_cnt - h0, 4);
    check("t4_nice", nice_count, 3);
    do_reset();

    // eof with last string, one engine busy, simultaneous completions
    eng_lat[0] = 10000; eng_lat[1] = 10000; hold[0] = 1;
    h0 = hs_cnt;
    exp_grant.push_back(1);
    send_str(mk(1), 1, 0, 1);
    repeat (6) @(negedge clk);
    hold[0] = 0;
    repeat (2) @(negedge clk);
    r0 = res_cnt;
    exp_grant.push_back(0);
    send_str(mk(1), 1, 1, 1);
    repeat (12) @(negedge clk);
    #1;
    check("t5_grants", hs_cnt - h0, 2);
    check("t5_no_early_result", res_cnt - r0, 0);
    nb = nice_count;
    @(posedge clk);
    force_mask = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5_nice_plus2", nice_count, nb + RW'(2));
    wait_result(10, "t5", lat);
    check("t5_after_done", last_res_cyc > last_done_cyc, 1);
    do_reset();

    // reset with queued and in-flight work
    h0 = hs_cnt;
    for (int k = 0; k < 4; k++) send_str(mk(1), 1, 0, 1);
    repeat (4) @(negedge clk);
    #1;
    check("t6_inflight", hs_cnt - h0, 2);
    @(posedge clk);
    force_mask = 2'b01;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_nice", nice_count, 0);
    check("t6_rst_result", result_valid, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_req_valid", eng_req_valid, 0);
    exp_data.delete(); exp_grant.delete(); exp_result.delete();
    exp_total = 0;
    @(posedge clk);
    force_mask = 2'b10;
    repeat (3) @(negedge clk);
    #1;
    check("t6_late_done_ignored", nice_count, 0);
    eng_lat[0] = 5; eng_lat[1] = 5;
    send_str(mk(1), 1, 0, 1);
    repeat (12) @(negedge clk);
    send_eof();
    wait_result(20, "t6", lat);
    check("t6_nice", nice_count, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
